int_to_fp_arbiter: RTL and testbench
====================================

INT_TO_FP_ARBITER -- requirements
Module: int_to_fp_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3: number of requester streams (2..8).
REQ-002 SHALL have parameter DATA_W, default 21: integer sample width.
REQ-003 SHALL have parameter RES_W, default 32: float result width.
REQ-004 SHALL have parameter LATENCY, default 6: converter pipeline latency; tag FIFO depth = LATENCY+2.
REQ-005 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-006 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-007 SHALL have port req_valid  in  NUM_REQ  per-requester valid.
REQ-008 SHALL have port req_data  in  NUM_REQ*DATA_W  requester i occupies bits [i*DATA_W +: DATA_W].
REQ-009 SHALL have port req_ready  out  NUM_REQ  per-requester ready.
REQ-010 SHALL have port cvt_valid  out  1  valid to converter sink.
REQ-011 SHALL have port cvt_data  out  DATA_W  granted requester's data.
REQ-012 SHALL have port cvt_ready  in  1  converter sink ready.
REQ-013 SHALL have port res_valid  in  1  converter result valid.
REQ-014 SHALL have port res_data  in  RES_W  converter result.
REQ-015 SHALL have port res_ready  out  1  result ready to converter.
REQ-016 SHALL have port rsp_valid  out  NUM_REQ  per-requester result valid.
REQ-017 SHALL have port rsp_data  out  RES_W  result, broadcast to all requesters.
REQ-018 SHALL have port rsp_ready  in  NUM_REQ  per-requester result ready.
REQ-019 SHALL have port err  out  1  sticky protocol error flag.

Function
REQ-020 SHALL select grant combinationally, round-robin: first i with req_valid[i], searching from last_grant+1 with wrap at NUM_REQ-1 -> 0.
REQ-021 SHALL drive cvt_valid = (any req_valid) && !tag_full, and cvt_data = req_data of granted index.
REQ-022 SHALL drive req_ready[i] = (grant==i) && cvt_ready && !tag_full; all other req_ready low.
REQ-023 SHALL, while cvt_valid && !cvt_ready, register a lock and hold the grant index unchanged on following cycles until the handshake completes.
REQ-024 SHALL, on issue handshake (cvt_valid && cvt_ready), push grant index into the tag FIFO, update last_grant, and clear lock.
REQ-025 SHALL drive, when tag FIFO non-empty with head h: rsp_valid[h] = res_valid, other rsp_valid low, res_ready = rsp_ready[h], rsp_data = res_data (zero-cycle pass-through).
REQ-026 SHALL pop the tag FIFO on res_valid && res_ready.
REQ-027 SHALL keep tag count unchanged on simultaneous push and pop, including when full or empty-with-push.
REQ-028 SHALL, when tag FIFO empty, drive res_ready high and all rsp_valid low; a res_valid in this state sets err and the result is discarded.
REQ-029 SHALL set err on push while full (unreachable in correct operation) and hold err until reset.
REQ-030 SHALL preserve per-requester result order and global issue order (FIFO).
REQ-031 SHALL add no latency on either path; throughput one sample per cycle when cvt_ready and responders ready.

Reset
REQ-032 SHALL, on rst high at a clock edge: empty tag FIFO, clear lock, set last_grant = NUM_REQ-1 (requester 0 wins first), clear err.
REQ-033 SHALL, during and the cycle after reset, hold cvt_valid, rsp_valid low only as implied by REQ-021/REQ-028 with empty state; in-flight converter results after reset mid-operation set err (controller also resets converter via the same rst).

Verification
REQ-034 SHALL cover: all 3 requesters valid continuously, cvt_ready=1 -> grants 0,1,2,0,1,2; each rsp arrives LATENCY cycles later on the issuing port.
REQ-035 SHALL cover: req1 valid, cvt_ready low 4 cycles, req0 asserts meanwhile -> grant stays 1, cvt_data stable, req1 issued first when cvt_ready rises.
REQ-036 SHALL cover: rsp_ready[2]=0 for 10 cycles with results pending for 2 -> res_ready low, tag FIFO fills to 8, cvt_valid drops, no data lost, order intact after release.
REQ-037 SHALL cover: res_valid pulse with empty FIFO -> err=1 held until rst; rst clears to 0.
REQ-038 SHALL cover: rst asserted with 5 in flight -> next cycle FIFO empty, first grant goes to requester 0.
REQ-039 SHALL cover: single requester 1 streaming value 21'h1FFFFF -> back-to-back issues every cycle, rsp_data equals converter result unaltered.

Source files
------------

// File: rtl/int_to_fp_arbiter.sv
// Round-robin arbiter feeding a shared int-to-float converter, with a tag FIFO
// that routes each converter result back to the requester that issued it.
module int_to_fp_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 21,
    parameter int RES_W   = 32,
    parameter int LATENCY = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      cvt_valid,
    output logic [DATA_W-1:0]         cvt_data,
    input  logic                      cvt_ready,
    input  logic                      res_valid,
    input  logic [RES_W-1:0]          res_data,
    output logic                      res_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [RES_W-1:0]          rsp_data,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    output logic                      err
);

    localparam int DEPTH = LATENCY + 2;
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] lock_idx;
    logic             lock;
    logic [IDX_W-1:0] rr_grant;
    logic [IDX_W-1:0] grant;
    logic [IDX_W-1:0] tag_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] tag_cnt;
    logic [IDX_W-1:0] head;
    logic             tag_full;
    logic             tag_empty;
    logic             any_valid;
    logic             issue;
    logic             retire;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign any_valid = |req_valid;
    assign tag_full  = (tag_cnt == CNT_W'(DEPTH));
    assign tag_empty = (tag_cnt == '0);
    assign head      = tag_mem[rd_ptr];

    // Scan from farthest to nearest so the nearest valid requester after last_grant wins.
    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        rr_grant = last_grant;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand     = (int'(last_grant) + k) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (req_valid[cand_idx]) begin
                rr_grant = cand_idx;
            end
        end
    end

    assign grant     = lock ? lock_idx : rr_grant;
    assign cvt_valid = any_valid && !tag_full;
    assign issue     = cvt_valid && cvt_ready;

    always_comb begin
        cvt_data  = '0;
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant == IDX_W'(i)) begin
                cvt_data     = req_data[i*DATA_W +: DATA_W];
                req_ready[i] = any_valid && cvt_ready && !tag_full;
            end
        end
    end

    always_comb begin
        rsp_valid = '0;
        res_ready = 1'b1;
        if (!tag_empty) begin
            rsp_valid[head] = res_valid;
            res_ready       = rsp_ready[head];
        end
    end

    assign rsp_data = res_data;
    assign retire   = res_valid && res_ready && !tag_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            tag_cnt    <= '0;
            lock       <= 1'b0;
            lock_idx   <= '0;
            last_grant <= IDX_W'(NUM_REQ - 1);
            err        <= 1'b0;
        end else begin
            if (issue) begin
                tag_mem[wr_ptr] <= grant;
                wr_ptr          <= ptr_inc(wr_ptr);
                last_grant      <= grant;
                lock            <= 1'b0;
            end else if (cvt_valid) begin
                lock     <= 1'b1;
                lock_idx <= grant;
            end
            if (retire) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({issue, retire})
                2'b10:   tag_cnt <= tag_cnt + CNT_W'(1);
                2'b01:   tag_cnt <= tag_cnt - CNT_W'(1);
                default: tag_cnt <= tag_cnt;
            endcase
            // A result with nothing outstanding has no owner and is dropped.
            if ((issue && tag_full) || (res_valid && tag_empty)) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_int_to_fp_arbiter.sv
// Bench for int_to_fp_arbiter: behavioural converter plus an issue-order
// scoreboard predicting arbitration, routing and the error flag.
module tb_int_to_fp_arbiter;

    localparam int NUM_REQ = 3;
    localparam int DATA_W  = 21;
    localparam int RES_W   = 32;
    localparam int LATENCY = 6;
    localparam int DEPTH   = LATENCY + 2;

    logic                      clk;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      cvt_valid;
    logic [DATA_W-1:0]         cvt_data;
    logic                      cvt_ready;
    logic                      res_valid;
    logic [RES_W-1:0]          res_data;
    logic                      res_ready;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [RES_W-1:0]          rsp_data;
    logic [NUM_REQ-1:0]        rsp_ready;
    logic                      err;

    int_to_fp_arbiter #(
        .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .RES_W(RES_W), .LATENCY(LATENCY)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .cvt_valid(cvt_valid), .cvt_data(cvt_data), .cvt_ready(cvt_ready),
        .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { int req; logic [31:0] res; int cyc; } tag_t;
    typedef struct { logic [20:0] d; int rdy; } cv_t;
    typedef struct { logic [2:0] rv; logic cr; logic [2:0] exp_rdy; logic exp_cv; } vec_t;

    tag_t mq[$];
    cv_t  conv_q[$];
    int   n_chk, n_err, cyc;
    int   m_last, m_lock_idx;
    bit   m_lock, m_err;
    bit   chk_lat, bogus;

    bit                 e_cv, e_push, e_pop, e_err_set, a_cpush, a_cpop, conv_drv;
    int                 e_gnt;
    logic [20:0]        e_data, a_cdata;
    logic [NUM_REQ-1:0] e_rdy, held;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] fp_of(input logic [20:0] d);
        logic [20:0] a;
        logic [31:0] m;
        int          msb;
        if (d == '0) return '0;
        a   = d[20] ? (~d + 21'd1) : d;
        msb = 0;
        for (int i = 0; i < 21; i++) if (a[i]) msb = i;
        m = {11'b0, a} << (23 - msb);
        return {d[20], 8'(127 + msb), m[22:0]};
    endfunction

    function automatic bit bit_at(input logic [NUM_REQ-1:0] v, input int i);
        logic [NUM_REQ-1:0] s;
        s = v >> i;
        return s[0];
    endfunction

    function automatic logic [20:0] slice(input logic [NUM_REQ*DATA_W-1:0] v, input int i);
        logic [NUM_REQ*DATA_W-1:0] s;
        s = v >> (i * DATA_W);
        return s[20:0];
    endfunction

    function automatic int rr_pick(input logic [NUM_REQ-1:0] rv);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (bit_at(rv, (m_last + k) % NUM_REQ)) return (m_last + k) % NUM_REQ;
        end
        return 0;
    endfunction

    task automatic model_reset();
        mq.delete();
        conv_q.delete();
        m_last = NUM_REQ - 1;
        m_lock = 1'b0;
        m_lock_idx = 0;
        m_err = 1'b0;
    endtask

    task automatic eval();
        bit                 any, full, exp_res_rdy;
        logic [NUM_REQ-1:0] exp_rsp_v;
        conv_drv = 1'b0;
        if (bogus) begin
            res_valid = 1'b1;
            res_data  = 32'hDEAD_BEEF;
        end else if (conv_q.size() > 0 && conv_q[0].rdy <= cyc) begin
            res_valid = 1'b1;
            res_data  = fp_of(conv_q[0].d);
            conv_drv  = 1'b1;
        end else begin
            res_valid = 1'b0;
            res_data  = $urandom;
        end
        #4;
        any   = |req_valid;
        full  = (mq.size() == DEPTH);
        e_cv  = any && !full;
        e_gnt = m_lock ? m_lock_idx : rr_pick(req_valid);
        e_rdy = (e_cv && cvt_ready) ? (NUM_REQ'(1) << e_gnt) : '0;
        e_data = slice(req_data, e_gnt);
        chk("cvt_valid", 64'(cvt_valid), 64'(e_cv));
        chk("req_ready", 64'(req_ready), 64'(e_rdy));
        if (e_cv) chk("cvt_data", 64'(cvt_data), 64'(e_data));
        if (mq.size() > 0) begin
            exp_rsp_v   = res_valid ? (NUM_REQ'(1) << mq[0].req) : '0;
            exp_res_rdy = bit_at(rsp_ready, mq[0].req);
        end else begin
            exp_rsp_v   = '0;
            exp_res_rdy = 1'b1;
        end
        chk("rsp_valid", 64'(rsp_valid), 64'(exp_rsp_v));
        chk("res_ready", 64'(res_ready), 64'(exp_res_rdy));
        chk("err", 64'(err), 64'(m_err));
        e_push    = e_cv && cvt_ready;
        e_pop     = (mq.size() > 0) && res_valid && exp_res_rdy;
        e_err_set = (mq.size() == 0) && res_valid;
        if (e_pop) begin
            chk("rsp_data", 64'(rsp_data), 64'(mq[0].res));
            if (chk_lat) chk("latency", 64'(cyc - mq[0].cyc), 64'(LATENCY));
        end
        a_cpush = cvt_valid && cvt_ready;
        a_cdata = cvt_data;
        a_cpop  = conv_drv && res_ready;
    endtask

    task automatic advance();
        tag_t t;
        cv_t  c;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (e_err_set) m_err = 1'b1;
            if (e_pop) void'(mq.pop_front());
            if (e_push) begin
                t.req = e_gnt; t.res = fp_of(e_data); t.cyc = cyc;
                mq.push_back(t);
                m_last = e_gnt;
                m_lock = 1'b0;
            end else if (e_cv) begin
                m_lock = 1'b1;
                m_lock_idx = e_gnt;
            end
            if (a_cpop) void'(conv_q.pop_front());
            if (a_cpush) begin
                c.d = a_cdata; c.rdy = cyc + LATENCY;
                conv_q.push_back(c);
            end
        end
        cyc++;
        #1;
    endtask

    task automatic step();
        eval();
        advance();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic drain();
        int i;
        req_valid = '0;
        cvt_ready = 1'b1;
        rsp_ready = '1;
        i = 0;
        while ((mq.size() > 0 || conv_q.size() > 0) && i < 200) begin
            step();
            i++;
        end
        if (mq.size() > 0 || conv_q.size() > 0) begin
            n_chk++; n_err++;
            $display("FAIL drain_timeout: %0d results still outstanding, required 0", mq.size());
        end
    endtask

    task automatic rand_drive();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!held[i]) begin
                req_valid[i] = 1'($urandom_range(0, 1));
                req_data[i*DATA_W +: DATA_W] = 21'($urandom);
            end
            rsp_ready[i] = ($urandom_range(0, 4) != 0);
        end
        cvt_ready = ($urandom_range(0, 3) != 0);
    endtask

    initial begin
        vec_t tbl[10];
        tbl[0] = '{3'b111, 1'b1, 3'b001, 1'b1};
        tbl[1] = '{3'b111, 1'b1, 3'b010, 1'b1};
        tbl[2] = '{3'b111, 1'b1, 3'b100, 1'b1};
        tbl[3] = '{3'b101, 1'b1, 3'b001, 1'b1};
        tbl[4] = '{3'b101, 1'b1, 3'b100, 1'b1};
        tbl[5] = '{3'b010, 1'b0, 3'b000, 1'b1};
        tbl[6] = '{3'b011, 1'b0, 3'b000, 1'b1};
        tbl[7] = '{3'b011, 1'b1, 3'b010, 1'b1};
        tbl[8] = '{3'b011, 1'b1, 3'b001, 1'b1};
        tbl[9] = '{3'b000, 1'b1, 3'b000, 1'b0};

        n_chk = 0; n_err = 0; cyc = 0;
        rst = 1'b1; req_valid = '0; req_data = '0; cvt_ready = 1'b0;
        rsp_ready = '1; res_valid = 1'b0; res_data = '0;
        bogus = 1'b0; chk_lat = 1'b0; held = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;

        // Arbitration table straight out of reset
        for (int v = 0; v < 10; v++) begin
            req_valid = tbl[v].rv;
            cvt_ready = tbl[v].cr;
            if (v < 5 || v > 7) req_data = {$urandom, $urandom};
            eval();
            chk("tbl_req_ready", 64'(req_ready), 64'(tbl[v].exp_rdy));
            chk("tbl_cvt_valid", 64'(cvt_valid), 64'(tbl[v].exp_cv));
            advance();
        end
        drain();

        // All requesters streaming: strict 0,1,2 rotation, fixed latency back
        do_reset();
        req_valid = '1; cvt_ready = 1'b1; rsp_ready = '1; chk_lat = 1'b1;
        for (int k = 0; k < 12; k++) begin
            req_data = {$urandom, $urandom};
            eval();
            chk("rr_seq", 64'(req_ready), 64'(NUM_REQ'(1) << (k % 3)));
            advance();
        end
        drain();
        chk_lat = 1'b0;

        // Stalled converter holds the grant on requester 1
        req_valid = 3'b010; cvt_ready = 1'b0;
        req_data[1*DATA_W +: DATA_W] = 21'h0ABCDE;
        for (int k = 0; k < 4; k++) begin
            if (k == 1) req_valid = 3'b011;
            eval();
            chk("stall_data", 64'(cvt_data), 64'(21'h0ABCDE));
            chk("stall_rdy", 64'(req_ready), 64'(3'b000));
            advance();
        end
        cvt_ready = 1'b1;
        eval();
        chk("release_grant", 64'(req_ready), 64'(3'b010));
        advance();
        req_valid = 3'b001;
        step();
        drain();

        // Requester 2 refuses results: FIFO fills and issue stops
        req_valid = 3'b100; cvt_ready = 1'b1; rsp_ready = 3'b011;
        for (int k = 0; k < 10; k++) begin
            req_data[2*DATA_W +: DATA_W] = 21'(k * 4099 + 7);
            step();
        end
        eval();
        chk("fill_cvt_valid", 64'(cvt_valid), 64'(1'b0));
        chk("fill_res_ready", 64'(res_ready), 64'(1'b0));
        advance();
        drain();

        // Orphan result sets a sticky error
        bogus = 1'b1;
        step();
        bogus = 1'b0;
        repeat (4) step();
        eval();
        chk("err_sticky", 64'(err), 64'(1'b1));
        advance();
        do_reset();
        eval();
        chk("err_cleared", 64'(err), 64'(1'b0));
        advance();

        // Reset with five conversions in flight
        req_valid = '1; cvt_ready = 1'b1; rsp_ready = '1;
        for (int k = 0; k < 5; k++) begin
            req_data = {$urandom, $urandom};
            step();
        end
        do_reset();
        eval();
        chk("post_rst_grant", 64'(req_ready), 64'(3'b001));
        chk("post_rst_rsp_valid", 64'(rsp_valid), 64'(3'b000));
        advance();
        drain();

        // Single requester streaming the all-ones sample
        req_valid = 3'b010; cvt_ready = 1'b1; rsp_ready = '1; chk_lat = 1'b1;
        req_data[1*DATA_W +: DATA_W] = 21'h1FFFFF;
        for (int k = 0; k < 10; k++) begin
            eval();
            chk("b2b_rdy", 64'(req_ready), 64'(3'b010));
            if (res_valid) chk("b2b_rsp_data", 64'(rsp_data), 64'(32'hBF80_0000));
            advance();
        end
        drain();
        chk_lat = 1'b0;

        // Random traffic with backpressure on both sides
        held = '0;
        for (int k = 0; k < 400; k++) begin
            rand_drive();
            eval();
            held = req_valid & ~e_rdy;
            advance();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
        $fatal(1);
    end

endmodule
